uart_receiver: RTL

Serial-to-parallel UART receiver that sits between the board RX pin and the CPU_Pipeline peripheral bus. It synchronises the asynchronous RX line, detects and validates start bits, samples 8N1 frames LSB-first at mid-bit, and presents each received byte to the CPU through a level-valid/pulse-acknowledge handshake. It also reports framing and overrun errors. The default configuration is 100 MHz system clock and 9600 baud (one bit ≈ 104167 ns).

---
 rtl/uart_receiver_if.sv | 27 ++
 rtl/uart_receiver.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/uart_receiver_if.sv
// rtl/uart_receiver_if.sv - CPU-side byte handshake between the UART receiver and the peripheral bus
interface uart_receiver_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;
  logic       rx_frame_err;
  logic       rx_overrun;
  logic       rx_busy;

  modport master (
    output rx_data,
    output rx_valid,
    output rx_frame_err,
    output rx_overrun,
    output rx_busy,
    input  rx_ack
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  rx_frame_err,
    input  rx_overrun,
    input  rx_busy,
    output rx_ack
  );
endinterface

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receiver with mid-bit sampling, framing and overrun reporting
module uart_receiver #(
  parameter int CLK_HZ = 100000000,
  parameter int BAUD   = 9600
) (
  input  logic           clk,
  input  logic           resetk,
  input  logic           RX,
  uart_receiver_if.master bus
);

  localparam int DIV  = CLK_HZ / BAUD;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV);
  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_bcnt;
  logic [CW-1:0] w_bcnt_nxt;
  logic [2:0]    r_bit;
  logic [2:0]    w_bit_nxt;
  logic [7:0]    r_shift;
  logic          r_rx_meta;
  logic          r_rx_s;
  logic [7:0]    r_data;
  logic          r_valid;
  logic          r_frame_err;
  logic          r_overrun;
  logic          w_shift_en;
  logic          w_accept;
  logic          w_ferr;

  // Synchroniser idles high so reset never looks like a start edge.
  always_ff @(posedge clk or negedge resetk) begin
    if (!resetk) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= RX;
      r_rx_s    <= r_rx_meta;
    end
  end

  always_ff @(posedge clk or negedge resetk) begin
    if (!resetk) begin
      r_state <= S_IDLE;
      r_bcnt  <= '0;
      r_bit   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_bcnt  <= w_bcnt_nxt;
      r_bit   <= w_bit_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_bcnt_nxt  = r_bcnt;
    w_bit_nxt   = r_bit;
    w_shift_en  = 1'b0;
    w_accept    = 1'b0;
    w_ferr      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_bcnt_nxt = '0;
        if (!r_rx_s) w_state_nxt = S_START;
      end
      S_START: begin
        if (r_bcnt == HALF_M1) begin
          w_bcnt_nxt  = '0;
          w_bit_nxt   = '0;
          w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
        end else begin
          w_bcnt_nxt = r_bcnt + CW'(1);
        end
      end
      S_DATA: begin
        if (r_bcnt == DIV_M1) begin
          w_bcnt_nxt = '0;
          w_shift_en = 1'b1;
          if (r_bit == 3'd7) w_state_nxt = S_STOP;
          else               w_bit_nxt   = r_bit + 3'd1;
        end else begin
          w_bcnt_nxt = r_bcnt + CW'(1);
        end
      end
      S_STOP: begin
        if (r_bcnt == DIV_M1) begin
          w_bcnt_nxt = '0;
          if (r_rx_s) begin
            w_accept    = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_ferr      = 1'b1;
            w_state_nxt = S_BREAK;
          end
        end else begin
          w_bcnt_nxt = r_bcnt + CW'(1);
        end
      end
      S_BREAK: begin
        w_bcnt_nxt = '0;
        if (r_rx_s) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_bcnt_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetk) begin
    if (!resetk) begin
      r_shift <= '0;
    end else if (w_shift_en) begin
      r_shift <= {r_rx_s, r_shift[7:1]};
    end
  end

  // An ack coinciding with an accept consumes the old byte, so the new one replaces it cleanly.
  always_ff @(posedge clk or negedge resetk) begin
    if (!resetk) begin
      r_data      <= 8'h00;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_ferr;
      if (w_accept) begin
        if (!r_valid || bus.rx_ack) begin
          r_data    <= r_shift;
          r_valid   <= 1'b1;
          r_overrun <= 1'b0;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (bus.rx_ack && r_valid) begin
        r_valid   <= 1'b0;
        r_overrun <= 1'b0;
      end
    end
  end

  assign bus.rx_data      = r_data;
  assign bus.rx_valid     = r_valid;
  assign bus.rx_frame_err = r_frame_err;
  assign bus.rx_overrun   = r_overrun;
  assign bus.rx_busy      = (r_state != S_IDLE);

endmodule
